// File: rtl/freq_gate_counter_if.sv
// Measurement bus between the gate counter and its consumer: the pulse train and
// enable in, plus the result with its valid/ack handshake and status flags out.
interface freq_gate_counter_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                   pulse_in;
    logic                   enable;
    logic                   result_ack;
    logic [COUNT_WIDTH-1:0] result;
    logic                   result_valid;
    logic                   overflow;
    logic                   overrun;

    modport master (
        input  pulse_in,
        input  enable,
        input  result_ack,
        output result,
        output result_valid,
        output overflow,
        output overrun
    );

    modport slave (
        output pulse_in,
        output enable,
        output result_ack,
        input  result,
        input  result_valid,
        input  overflow,
        input  overrun
    );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronised rising edges of pulse_in over
// back-to-back windows of GATE_CYCLES clocks and hands each count off via valid/ack.
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    freq_gate_counter_if.master   bus
);
    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [0:0]             state_q, state_d;
    logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                   win_ovf_q, win_ovf_d;
    logic [COUNT_WIDTH-1:0] result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;
    logic                   overrun_q, overrun_d;

    logic                   sync_out;
    logic                   pulse_edge;
    logic                   pulse_max;
    logic                   cnt_inc;
    logic                   ovf_hit;
    logic [COUNT_WIDTH-1:0] pulse_cnt_inc;
    logic                   latch;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign pulse_edge = sync_out & ~dly_q;
    assign pulse_max  = &pulse_cnt_q;

    always_comb begin
        state_d       = state_q;
        gate_cnt_d    = gate_cnt_q;
        pulse_cnt_d   = pulse_cnt_q;
        win_ovf_d     = win_ovf_q;
        result_d      = result_q;
        overflow_d    = overflow_q;
        overrun_d     = overrun_q;
        latch         = 1'b0;
        cnt_inc       = pulse_edge & ~pulse_max;
        ovf_hit       = pulse_edge & pulse_max;
        pulse_cnt_inc = pulse_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, cnt_inc};

        case (state_q)
            ST_GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // Last cycle's edge is folded into the result; the next window
                    // starts immediately so windows stay exactly GATE_CYCLES long.
                    latch       = 1'b1;
                    result_d    = pulse_cnt_inc;
                    overflow_d  = win_ovf_q | ovf_hit;
                    overrun_d   = overrun_q | (valid_q & ~bus.result_ack);
                    gate_cnt_d  = '0;
                    pulse_cnt_d = '0;
                    win_ovf_d   = 1'b0;
                    state_d     = bus.enable ? ST_GATE : ST_IDLE;
                end else if (!bus.enable) begin
                    gate_cnt_d  = '0;
                    pulse_cnt_d = '0;
                    win_ovf_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    gate_cnt_d  = gate_cnt_q + 1'b1;
                    pulse_cnt_d = pulse_cnt_inc;
                    win_ovf_d   = win_ovf_q | ovf_hit;
                end
            end
            default: begin
                gate_cnt_d  = '0;
                pulse_cnt_d = '0;
                win_ovf_d   = 1'b0;
                state_d     = bus.enable ? ST_GATE : ST_IDLE;
            end
        endcase

        // A fresh result beats a simultaneous acknowledge.
        valid_d = latch ? 1'b1 : (bus.result_ack ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            dly_q       <= 1'b0;
            state_q     <= ST_IDLE;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            win_ovf_q   <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
            dly_q       <= sync_out;
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            win_ovf_q   <= win_ovf_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: periodic pulse trains with known edge
// counts per window, plus hand-timed boundary, handshake, enable and reset sequences.
module tb_freq_gate_counter;
    localparam int GATE = 100;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    freq_gate_counter_if #(.COUNT_WIDTH(CW)) bus ();

    freq_gate_counter #(
        .GATE_CYCLES(GATE),
        .COUNT_WIDTH(CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   half = 0;          // >0: free-running square wave with this half-period
    logic man_level = 1'b0;  // pulse level used when half == 0

    typedef struct {
        int half;
        int exp_result;
        int exp_ovf;
    } vec_t;

    vec_t vecs [7];

    // Pulse source: changes only on falling clk edges.
    initial begin : pulse_gen
        int   cnt;
        logic lvl;
        cnt = 0;
        lvl = 1'b0;
        bus.pulse_in = 1'b0;
        forever begin
            @(negedge clk);
            if (half > 0) begin
                cnt++;
                if (cnt >= half) begin
                    cnt = 0;
                    lvl = ~lvl;
                end
                bus.pulse_in = lvl;
            end else begin
                cnt = 0;
                lvl = 1'b0;
                bus.pulse_in = man_level;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.result_ack = 1'b1;
        step(1);
        bus.result_ack = 1'b0;
    endtask

    // Returns the number of rising clk edges until result_valid is seen high.
    task automatic wait_latch(input int limit, output int n);
        bit done;
        done = 1'b0;
        n = -1;
        for (int i = 1; i <= limit && !done; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) begin
                n = i;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_latch: result_valid not seen within %0d cycles", limit);
        end
    endtask

    initial begin : main
        int n;
        // Each count is 100/period for a continuous train: windows are exactly 100 cycles.
        vecs[0] = '{half: 5,  exp_result: 10, exp_ovf: 0};
        vecs[1] = '{half: 2,  exp_result: 15, exp_ovf: 1};  // 25 edges, saturates
        vecs[2] = '{half: 10, exp_result: 5,  exp_ovf: 0};
        vecs[3] = '{half: 1,  exp_result: 15, exp_ovf: 1};  // 50 edges
        vecs[4] = '{half: 25, exp_result: 2,  exp_ovf: 0};
        vecs[5] = '{half: 50, exp_result: 1,  exp_ovf: 0};
        vecs[6] = '{half: 0,  exp_result: 0,  exp_ovf: 0};

        bus.enable     = 1'b0;
        bus.result_ack = 1'b0;
        step(3);
        chk("reset_result",   bus.result,       0);
        chk("reset_valid",    bus.result_valid, 0);
        chk("reset_overflow", bus.overflow,     0);
        chk("reset_overrun",  bus.overrun,      0);

        @(negedge clk);
        rst = 1'b1;
        bus.enable = 1'b1;
        wait_latch(300, n);
        // The cycle in which rst rises counts as the first one.
        chk("first_latency", n + 1, GATE + 2);
        chk("first_result",  bus.result, 0);
        $display("first window: result=%0d after %0d edges", bus.result, n);
        ack_pulse();

        for (int v = 0; v < 7; v++) begin
            half = vecs[v].half;
            wait_latch(300, n);   // window disturbed by the period change
            ack_pulse();
            wait_latch(300, n);
            chk("vec_window",   n, GATE - 1);
            chk("vec_result",   bus.result,       vecs[v].exp_result);
            chk("vec_overflow", bus.overflow,     vecs[v].exp_ovf);
            chk("vec_valid",    bus.result_valid, 1);
            chk("vec_overrun",  bus.overrun,      0);
            $display("vec %0d: half=%0d result=%0d overflow=%0b", v, vecs[v].half,
                     bus.result, bus.overflow);
            ack_pulse();
        end

        // Edge landing on gate_cnt == 99, then one on gate_cnt == 0 two windows on.
        wait_latch(300, n);
        ack_pulse();
        step(96);
        man_level = 1'b1;
        step(2);
        man_level = 1'b0;
        step(1);
        chk("edge_last_valid",  bus.result_valid, 1);
        chk("edge_last_result", bus.result,       1);
        $display("boundary last-cycle edge: result=%0d", bus.result);
        ack_pulse();
        step(97);
        man_level = 1'b1;
        step(2);
        chk("edge_gap_valid",  bus.result_valid, 1);
        chk("edge_gap_result", bus.result,       0);
        man_level = 1'b0;
        ack_pulse();
        step(99);
        chk("edge_first_valid",  bus.result_valid, 1);
        chk("edge_first_result", bus.result,       1);
        $display("boundary first-cycle edge: result=%0d", bus.result);
        ack_pulse();

        // Drop enable at gate_cnt == 50.
        half = 5;
        wait_latch(300, n);
        ack_pulse();
        wait_latch(300, n);
        chk("pre_drop_result", bus.result, 10);
        ack_pulse();
        step(49);
        bus.enable = 1'b0;
        step(150);
        chk("drop_valid",  bus.result_valid, 0);
        chk("drop_result", bus.result,       10);
        bus.enable = 1'b1;
        wait_latch(300, n);
        chk("reenable_latency", n, GATE + 1);
        chk("reenable_result",  bus.result, 10);
        $display("re-enabled window: result=%0d after %0d cycles", bus.result, n);

        // Ack coincident with the next latch: valid stays, no overrun.
        step(99);
        bus.result_ack = 1'b1;
        step(1);
        bus.result_ack = 1'b0;
        chk("coinc_valid",   bus.result_valid, 1);
        chk("coinc_overrun", bus.overrun,      0);
        chk("coinc_result",  bus.result,       10);
        ack_pulse();
        chk("ack_clears_valid", bus.result_valid, 0);

        // Two latches without an ack.
        wait_latch(300, n);
        step(99);
        chk("overrun_before", bus.overrun, 0);
        step(1);
        chk("overrun_set",       bus.overrun,      1);
        chk("overrun_valid",     bus.result_valid, 1);
        chk("overrun_result",    bus.result,       10);
        $display("overwrite: overrun=%0b result=%0d", bus.overrun, bus.result);
        ack_pulse();
        wait_latch(300, n);
        chk("overrun_sticky", bus.overrun, 1);

        // Asynchronous reset between clock edges.
        half = 0;
        step(5);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_result",   bus.result,       0);
        chk("async_valid",    bus.result_valid, 0);
        chk("async_overflow", bus.overflow,     0);
        chk("async_overrun",  bus.overrun,      0);
        step(3);
        @(negedge clk);
        rst = 1'b1;
        wait_latch(300, n);
        chk("post_reset_latency", n + 1, GATE + 2);
        chk("post_reset_result",  bus.result,  0);
        chk("post_reset_overrun", bus.overrun, 0);
        $display("after reset: result=%0d after %0d cycles", bus.result, n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Downstream consumer of pulse_divider. Counts the rising edges of the divided pulse train over a fixed gate window of GATE_CYCLES clk cycles.
- At the end of each window it latches the count as a frequency measurement and presents it with a valid/ack handshake.
- pulse_in is asynchronous to clk and is synchronised internally.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); must be >= 2.
- COUNT_WIDTH, 32, width of the pulse counter and the result.
- SYNC_STAGES, 2, synchroniser flip-flops on pulse_in; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pulse_in  input  1  divided pulse train from pulse_divider, asynchronous to clk.
- enable  input  1  1 = run back-to-back gate windows; 0 = stop and discard any partial window.
- result  output  COUNT_WIDTH  edge count of the last completed window.
- result_valid  output  1  a new result is available; held until acknowledged.
- result_ack  input  1  consumer acknowledge; clears result_valid.
- overflow  output  1  the pulse counter saturated during the window that produced result.
- overrun  output  1  sticky; a result was overwritten before it was acknowledged.

Behaviour:
- Reset (rst = 0, asynchronous):
  - synchroniser, edge detector, gate counter and pulse counter all go to 0;
  - FSM goes to IDLE;
  - result, result_valid, overflow and overrun all go to 0.
- Synchroniser: SYNC_STAGES flip-flops, followed by one delay register.
- Edge detection: edge = sync_out & ~delayed. An edge is one clk wide, SYNC_STAGES+1 cycles after pulse_in rises.
- FSM states: IDLE and GATE.
- IDLE:
  - gate_cnt = 0 and pulse_cnt = 0;
  - enable = 1 moves to GATE on the next cycle;
  - edges seen while in IDLE are ignored.
- GATE:
  - gate_cnt increments each cycle from 0 to GATE_CYCLES-1;
  - pulse_cnt increments on each edge and saturates at 2^COUNT_WIDTH-1;
  - an edge arriving while pulse_cnt is already at max sets the window-overflow flag.
- Last gate cycle (gate_cnt == GATE_CYCLES-1):
  - an edge in this cycle is included in the count;
  - on the next clk: result <= final count, overflow <= window flag, result_valid <= 1;
  - gate_cnt, pulse_cnt and the window flag clear.
  - If enable = 1, the FSM stays in GATE with no dead cycle, so consecutive windows are exactly GATE_CYCLES long. If enable = 0, it goes to IDLE.
- enable falls mid-window: go to IDLE on the next clk, discard the partial count, and do not update result or result_valid.
- Handshake:
  - result_ack = 1 while result_valid = 1 clears result_valid on the next clk;
  - result_ack while result_valid = 0 has no effect.
- Overwrite without acknowledge:
  - a new result latched while result_valid = 1 and result_ack = 0 overwrites result and sets overrun;
  - overrun clears only on reset.
- Simultaneous ack and latch: the new result wins, result_valid stays 1, overrun is not set.
- Latency: a window's last counted edge appears in result one clk after the window's last cycle.

Test Plan:
1. Basic count: GATE_CYCLES=100, enable=1, pulse_in toggling with a 10-clk period (starting >3 cycles before GATE) -> result=10, overflow=0, result_valid=1 at cycle 101 of the window.
2. Boundary edge: align an edge so it reaches the detector at gate_cnt=99 -> it is counted in the current window; an edge at gate_cnt=0 of the next window is counted in that window.
3. Saturation: COUNT_WIDTH=4, GATE_CYCLES=100, 20 edges in the window -> result=15, overflow=1; next window with 5 edges -> result=5, overflow=0.
4. Handshake/overrun:
   - no ack across two windows -> result updated, overrun=1 and stays 1;
   - ack coincident with the latch cycle -> result_valid=1, overrun unchanged.
5. enable dropped at gate_cnt=50 -> FSM IDLE, result and result_valid unchanged; re-enable -> a fresh full window with a correct count.
6. rst pulled low mid-window, asynchronously between clk edges -> all outputs 0 immediately; after release with enable=1 -> the first result appears GATE_CYCLES+2 cycles later.
